// File: rtl/wb_port_arbiter_if.sv
// Writeback request / bank write interface for wb_port_arbiter.
// Signal names are given from the arbiter's point of view:
//   req_valid_i    per-requester write request
//   req_idx_i      packed destination cell per requester ([r*IDX_W +: IDX_W])
//   req_data_i     packed write data per requester ([r*DATA_WIDTH +: DATA_WIDTH])
//   req_ready_o    per-requester grant (combinational)
//   write1_en_o    one-hot port-1 write enable into the bank
//   write2_en_o    one-hot port-2 write enable into the bank
//   data1_o        port-1 write data, shared by all cells
//   data2_o        port-2 write data, shared by all cells
//   conflict_cnt_o saturating count of same-destination blocks
// Modports: slave = arbiter side, master = requester/bank side.
interface wb_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_REGS   = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 16;

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*IDX_W-1:0]      req_idx_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REGS-1:0]           write1_en_o;
    logic [NUM_REGS-1:0]           write2_en_o;
    logic [DATA_WIDTH-1:0]         data1_o;
    logic [DATA_WIDTH-1:0]         data2_o;
    logic [CNT_W-1:0]              conflict_cnt_o;

    modport slave (
        input  req_valid_i,
        input  req_idx_i,
        input  req_data_i,
        output req_ready_o,
        output write1_en_o,
        output write2_en_o,
        output data1_o,
        output data2_o,
        output conflict_cnt_o
    );

    modport master (
        output req_valid_i,
        output req_idx_i,
        output req_data_i,
        input  req_ready_o,
        input  write1_en_o,
        input  write2_en_o,
        input  data1_o,
        input  data2_o,
        input  conflict_cnt_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-port arbiter for a bank of dual-write-port storage cells.
// Grants up to two valid requesters per cycle in round-robin order, never two
// to the same cell, and drives registered one-hot write enables plus shared
// data buses into the bank one cycle after the handshake.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous, active-high reset
//   bus  wb_port_arbiter_if.slave (requests, grants, bank write ports, counter)
module wb_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    // Registered state
    logic [PTR_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [NUM_REGS-1:0]   wr1_en_q,  wr1_en_d;
    logic [NUM_REGS-1:0]   wr2_en_q,  wr2_en_d;
    logic [DATA_WIDTH-1:0] data1_q,   data1_d;
    logic [DATA_WIDTH-1:0] data2_q,   data2_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    // Arbitration results for the current cycle
    logic                  a_found, b_found;
    logic [PTR_W-1:0]      a_sel, b_sel;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic                  a_gnt, b_gnt;
    logic                  blocked;
    logic [NUM_REQ-1:0]    ready_c;

    // Increment a requester number modulo NUM_REQ (NUM_REQ need not be a power of 2)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    // Round-robin scan: first valid is A, next valid with a different idx is B
    always_comb begin
        int unsigned      pos;
        logic [PTR_W-1:0] r;
        logic [IDX_W-1:0] r_idx;

        a_found = 1'b0;
        b_found = 1'b0;
        a_sel   = '0;
        b_sel   = '0;
        idx_a   = '0;
        idx_b   = '0;
        blocked = 1'b0;
        pos     = 0;
        r       = '0;
        r_idx   = '0;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            r     = PTR_W'(pos);
            r_idx = bus.req_idx_i[r*IDX_W +: IDX_W];
            if (bus.req_valid_i[r]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_sel   = r;
                    idx_a   = r_idx;
                end else if (!b_found) begin
                    // Only requesters skipped before B (or after A with no B) count as blocked
                    if (r_idx == idx_a) begin
                        blocked = 1'b1;
                    end else begin
                        b_found = 1'b1;
                        b_sel   = r;
                        idx_b   = r_idx;
                    end
                end
            end
        end
    end

    // Grants are suppressed during reset so nothing transfers in that cycle
    assign a_gnt = a_found & ~rst;
    assign b_gnt = b_found & ~rst;

    always_comb begin
        ready_c = '0;
        if (a_gnt) begin
            ready_c[a_sel] = 1'b1;
        end
        if (b_gnt) begin
            ready_c[b_sel] = 1'b1;
        end
    end

    // Next-state: pointer, output stage and conflict counter
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr1_en_d = '0;
        wr2_en_d = '0;
        data1_d  = data1_q;
        data2_d  = data2_q;
        cnt_d    = cnt_q;

        if (b_gnt) begin
            rr_ptr_d = ptr_inc(b_sel);
        end else if (a_gnt) begin
            rr_ptr_d = ptr_inc(a_sel);
        end

        if (a_gnt) begin
            wr1_en_d = NUM_REGS'(1) << idx_a;
            data1_d  = bus.req_data_i[a_sel*DATA_WIDTH +: DATA_WIDTH];
        end
        if (b_gnt) begin
            wr2_en_d = NUM_REGS'(1) << idx_b;
            data2_d  = bus.req_data_i[b_sel*DATA_WIDTH +: DATA_WIDTH];
        end

        if (blocked && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr1_en_q <= '0;
            wr2_en_q <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr1_en_q <= wr1_en_d;
            wr2_en_q <= wr2_en_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_ready_o    = ready_c;
    assign bus.write1_en_o    = wr1_en_q;
    assign bus.write2_en_o    = wr2_en_q;
    assign bus.data1_o        = data1_q;
    assign bus.data2_o        = data2_q;
    assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned NUM_REGS   = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wb_port_arbiter_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .NUM_REGS   (NUM_REGS)
    ) bus ();

    wb_port_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 4'b1111;
        bus.req_idx_i   = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req_data_i  = '1;
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b exp 0000", bus.req_ready_o);
        end
        tick();
        bus.req_valid_i = '0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.write1_en_o !== 8'h00 || bus.write2_en_o !== 8'h00 ||
                bus.data1_o !== 32'h0 || bus.data2_o !== 32'h0 ||
                bus.conflict_cnt_o !== 16'h0 || bus.req_ready_o !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: en1=%h en2=%h d1=%h d2=%h cnt=%h rdy=%b exp all 0",
                         c, bus.write1_en_o, bus.write2_en_o, bus.data1_o, bus.data2_o,
                         bus.conflict_cnt_o, bus.req_ready_o);
            end
            n_cmp++;
            if (dut.rr_ptr_q !== 2'd0) begin
                n_err++;
                $display("FAIL reset_rr[%0d]: got %0d exp 0", c, dut.rr_ptr_q);
            end
        end
    endtask

    task automatic test_two_distinct();
        do_reset();
        bus.req_valid_i = 4'b0101;
        bus.req_idx_i   = {3'd0, 3'd5, 3'd0, 3'd3};
        bus.req_data_i  = {32'h0, 32'hB, 32'h0, 32'hA};
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0101) begin
            n_err++;
            $display("FAIL two_ready: got %b exp 0101", bus.req_ready_o);
        end
        tick();
        bus.req_valid_i = '0;
        n_cmp++;
        if (bus.write1_en_o !== 8'h08 || bus.data1_o !== 32'hA) begin
            n_err++;
            $display("FAIL two_port1: en1=%h d1=%h exp 08/a", bus.write1_en_o, bus.data1_o);
        end
        n_cmp++;
        if (bus.write2_en_o !== 8'h20 || bus.data2_o !== 32'hB) begin
            n_err++;
            $display("FAIL two_port2: en2=%h d2=%h exp 20/b", bus.write2_en_o, bus.data2_o);
        end
        n_cmp++;
        if (dut.rr_ptr_q !== 2'd3) begin
            n_err++;
            $display("FAIL two_rr: got %0d exp 3", dut.rr_ptr_q);
        end
        tick();
        n_cmp++;
        if (bus.write1_en_o !== 8'h00 || bus.write2_en_o !== 8'h00 ||
            bus.data1_o !== 32'hA || bus.data2_o !== 32'hB) begin
            n_err++;
            $display("FAIL two_pulse: en1=%h en2=%h d1=%h d2=%h exp 00/00/a/b",
                     bus.write1_en_o, bus.write2_en_o, bus.data1_o, bus.data2_o);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        bus.req_valid_i = 4'b1010;
        bus.req_idx_i   = {3'd4, 3'd0, 3'd4, 3'd0};
        bus.req_data_i  = {32'h33, 32'h0, 32'h11, 32'h0};
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0010) begin
            n_err++;
            $display("FAIL conf_ready0: got %b exp 0010", bus.req_ready_o);
        end
        tick();
        n_cmp++;
        if (bus.conflict_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL conf_cnt: got %0d exp 1", bus.conflict_cnt_o);
        end
        n_cmp++;
        if (bus.write1_en_o !== 8'h10 || bus.write2_en_o !== 8'h00 || bus.data1_o !== 32'h11) begin
            n_err++;
            $display("FAIL conf_out0: en1=%h en2=%h d1=%h exp 10/00/11",
                     bus.write1_en_o, bus.write2_en_o, bus.data1_o);
        end
        bus.req_valid_i = 4'b1000;
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b1000) begin
            n_err++;
            $display("FAIL conf_ready1: got %b exp 1000", bus.req_ready_o);
        end
        tick();
        bus.req_valid_i = '0;
        n_cmp++;
        if (bus.write1_en_o !== 8'h10 || bus.write2_en_o !== 8'h00 ||
            bus.data1_o !== 32'h33 || bus.conflict_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL conf_out1: en1=%h en2=%h d1=%h cnt=%0d exp 10/00/33/1",
                     bus.write1_en_o, bus.write2_en_o, bus.data1_o, bus.conflict_cnt_o);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_rdy [2];
        logic [7:0]  exp_en1 [2];
        logic [7:0]  exp_en2 [2];
        logic [31:0] exp_d1  [2];
        logic [31:0] exp_d2  [2];
        exp_rdy = '{4'b0011, 4'b1100};
        exp_en1 = '{8'h01, 8'h04};
        exp_en2 = '{8'h02, 8'h08};
        exp_d1  = '{32'h100, 32'h102};
        exp_d2  = '{32'h101, 32'h103};
        do_reset();
        bus.req_valid_i = 4'b1111;
        bus.req_idx_i   = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req_data_i  = {32'h103, 32'h102, 32'h101, 32'h100};
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready_o !== exp_rdy[c%2]) begin
                n_err++;
                $display("FAIL rot_ready[%0d]: got %b exp %b", c, bus.req_ready_o, exp_rdy[c%2]);
            end
            tick();
            n_cmp++;
            if (bus.write1_en_o !== exp_en1[c%2] || bus.write2_en_o !== exp_en2[c%2] ||
                bus.data1_o !== exp_d1[c%2] || bus.data2_o !== exp_d2[c%2]) begin
                n_err++;
                $display("FAIL rot_out[%0d]: en1=%h en2=%h d1=%h d2=%h exp %h/%h/%h/%h", c,
                         bus.write1_en_o, bus.write2_en_o, bus.data1_o, bus.data2_o,
                         exp_en1[c%2], exp_en2[c%2], exp_d1[c%2], exp_d2[c%2]);
            end
        end
        bus.req_valid_i = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_valid_i = 4'b0100;
        bus.req_idx_i   = {3'd0, 3'd7, 3'd0, 3'd0};
        for (int c = 0; c < 4; c++) begin
            bus.req_data_i = {32'h0, 32'h55 + 32'(c), 32'h0, 32'h0};
            #1;
            n_cmp++;
            if (bus.req_ready_o !== 4'b0100) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b exp 0100", c, bus.req_ready_o);
            end
            tick();
            n_cmp++;
            if (bus.write1_en_o !== 8'h80 || bus.write2_en_o !== 8'h00 ||
                bus.data1_o !== 32'h55 + 32'(c)) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: en1=%h en2=%h d1=%h exp 80/00/%h", c,
                         bus.write1_en_o, bus.write2_en_o, bus.data1_o, 32'h55 + 32'(c));
            end
        end
        bus.req_valid_i = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.req_valid_i = 4'b0011;
        bus.req_idx_i   = {3'd0, 3'd0, 3'd6, 3'd6};
        bus.req_data_i  = '0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            n_cmp++;
            if ((bus.write1_en_o & bus.write2_en_o) !== 8'h00) begin
                n_err++;
                $display("FAIL sat_overlap[%0d]: en1=%h en2=%h", i, bus.write1_en_o, bus.write2_en_o);
            end
            if (i == 65534) begin
                n_cmp++;
                if (bus.conflict_cnt_o !== 16'hFFFE) begin
                    n_err++;
                    $display("FAIL sat_pre: got %h exp fffe", bus.conflict_cnt_o);
                end
            end
            if (i == 65535 || i == 70000) begin
                n_cmp++;
                if (bus.conflict_cnt_o !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL sat_hold[%0d]: got %h exp ffff", i, bus.conflict_cnt_o);
                end
            end
        end
        bus.req_valid_i = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_valid_i = 4'b1010;
        bus.req_idx_i   = {3'd4, 3'd0, 3'd2, 3'd0};
        bus.req_data_i  = {32'h0, 32'h0, 32'h77, 32'h0};
        bus.req_idx_i   = {3'd4, 3'd0, 3'd4, 3'd0};
        tick();
        n_cmp++;
        if (dut.rr_ptr_q !== 2'd2 || bus.conflict_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL rmid_setup: rr=%0d cnt=%0d exp 2/1", dut.rr_ptr_q, bus.conflict_cnt_o);
        end
        bus.req_valid_i = 4'b0010;
        bus.req_idx_i   = {3'd0, 3'd0, 3'd2, 3'd0};
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_ready: got %b exp 0000", bus.req_ready_o);
        end
        tick();
        rst = 1'b0;
        bus.req_valid_i = '0;
        n_cmp++;
        if (bus.write1_en_o !== 8'h00 || bus.write2_en_o !== 8'h00 ||
            dut.rr_ptr_q !== 2'd0 || bus.conflict_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL rmid_after: en1=%h en2=%h rr=%0d cnt=%0d exp 00/00/0/0",
                     bus.write1_en_o, bus.write2_en_o, dut.rr_ptr_q, bus.conflict_cnt_o);
        end
        tick();
        n_cmp++;
        if (bus.write1_en_o !== 8'h00 || bus.write2_en_o !== 8'h00) begin
            n_err++;
            $display("FAIL rmid_noen: en1=%h en2=%h exp 00/00", bus.write1_en_o, bus.write2_en_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_idx_i   = '0;
        bus.req_data_i  = '0;
        tick();
        test_reset();
        test_two_distinct();
        test_conflict();
        test_rotation();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-port arbiter and sequencer for a bank of `NUM_REGS` dual-write-port storage cells. Each cell has two write ports: write1 has priority, and a simultaneous write2 to the same cell is dropped. The arbiter accepts writeback requests from `NUM_REQ` producers over valid/ready handshakes and grants up to two per cycle in round-robin order. It never issues two writes to the same cell in one cycle. It drives registered, one-hot write enables and shared data buses into the bank.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of each write data bus.
- `NUM_REQ`, 4, number of requesters (2..8).
- `NUM_REGS`, 8, number of storage cells in the bank (power of 2).
- `IDX_W`, `$clog2(NUM_REGS)`, derived destination index width; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  `NUM_REQ`  per-requester write request.
- `req_idx_i`  in  `NUM_REQ*IDX_W`  destination cell of each requester; requester r occupies bits `[r*IDX_W +: IDX_W]`.
- `req_data_i`  in  `NUM_REQ*DATA_WIDTH`  write data of each requester; same packing as `req_idx_i`.
- `req_ready_o`  out  `NUM_REQ`  grant; transfer occurs on a cycle with valid & ready.
- `write1_en_o`  out  `NUM_REGS`  one-hot port-1 write enable to the bank.
- `write2_en_o`  out  `NUM_REGS`  one-hot port-2 write enable to the bank.
- `data1_o`  out  `DATA_WIDTH`  port-1 write data, shared by all cells.
- `data2_o`  out  `DATA_WIDTH`  port-2 write data, shared by all cells.
- `conflict_cnt_o`  out  16  saturating count of same-destination blocks.

## Operation
- Round-robin pointer `rr_ptr` (`$clog2(NUM_REQ)` bits) sets the scan order: `rr_ptr`, `rr_ptr+1`, ..., wrapping mod `NUM_REQ`.
- Grant A (port 1): the first valid requester in scan order.
- Grant B (port 2): the next valid requester after A in scan order whose idx differs from A's idx.
- Valid requesters skipped between A and B (or after A when no B exists) because they target A's idx are blocked.
- `req_ready_o` is combinational from the current-cycle valid, idx and pointer. At most two bits are set.
- Requester contract: once valid is high, it stays high with stable idx and data until ready. The arbiter must not depend on this for correctness; it evaluates every cycle.
- Pointer update on each edge:
  - B granted: `rr_ptr <= B+1`.
  - Only A granted: `rr_ptr <= A+1`.
  - No grant: unchanged.
  - All arithmetic is mod `NUM_REQ`.
- Output stage, registered on each edge:
  - `write1_en_o <= onehot(idx_A)` when A is granted, else 0; `data1_o <= data_A` when A is granted, else holds.
  - Same rule for port 2 with B.
  - `write1_en_o` and `write2_en_o` never share a set bit.
- `conflict_cnt_o` increments by 1 on any cycle with at least one blocked requester. Saturates at `16'hFFFF`.
- Reset values: `rr_ptr` = 0, `write1_en_o` = 0, `write2_en_o` = 0, `data1_o` = 0, `data2_o` = 0, `conflict_cnt_o` = 0. `req_ready_o` is forced to 0 while `rst` is high.
- Reset mid-operation: a grant presented in the same cycle as `rst` is not accepted, and no write enable follows it.

## Timing
- Cycle N: valid & ready handshake; the arbiter registers the grant at the end of cycle N.
- Cycle N+1: `write*_en_o` and `data*_o` are presented to the bank.
- End of cycle N+1: the bank captures the write. The new value is readable in cycle N+2.
- Sustained throughput: 2 writes per cycle when two distinct destinations are pending.
- A single pending requester is granted every cycle, at 1 write per cycle.
- Enables are one-cycle pulses; no enable stays high without a fresh grant.

## Test plan
- Reset, then `req_valid_i`=0 for 3 cycles:
  - all outputs remain 0 and `rr_ptr` stays 0.
- Requesters 0 and 2 valid, idx 3 and 5, data `0xA`/`0xB`:
  - ready = `4'b0101` in cycle N;
  - in cycle N+1, `write1_en_o`=`8'h08`, `data1_o`=`0xA`, `write2_en_o`=`8'h20`, `data2_o`=`0xB`.
- Requesters 1 and 3 both valid with idx 4:
  - cycle N ready = `4'b0010`, `conflict_cnt_o` becomes 1;
  - cycle N+1 ready = `4'b1000`;
  - no cycle ever has both enables at bit 4.
- All 4 valid continuously with distinct idx:
  - grant pairs rotate (0,1), (2,3), (0,1), ...;
  - every requester is granted once per 2 cycles.
- Hold a same-idx conflict for 70000 cycles:
  - `conflict_cnt_o` saturates at `16'hFFFF` and does not wrap.
- Assert `rst` in the same cycle as a grant with requester 1 valid:
  - ready = 0 in that cycle;
  - in the next cycle, enables = 0, `rr_ptr` = 0 and the counter is cleared.
